// File: rtl/bck_lp_det.sv
`default_nettype none
// ============================================================================
// Module      : bck_lp_det
// Description : Backward-loop detector. Scans a 4-wide fetch bundle for short
//               backward conditional branches and filters them through a
//               small confidence table. The bundle is forwarded through one
//               register stage with a one-hot flag on a confirmed loop branch.
// Revision    : 1.0 - initial release
// ============================================================================
module bck_lp_det #(
    parameter logic [3:0] BR_OPCODE = 4'b1100,
    parameter int         MAX_BODY  = 64,
    parameter int         THRESH    = 2,
    parameter int         DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inst_in,
    input  logic [63:0] pc_in,
    input  logic [3:0]  inst_valid_in,
    input  logic        stll_ftch_in,
    input  logic        mis_pred_in,
    input  logic [1:0]  lbd_state_in,
    output logic [63:0] inst_out,
    output logic [63:0] pc_out,
    output logic [3:0]  inst_valid_out,
    output logic [3:0]  bck_lp_bus_out,
    output logic [15:0] tgt_addr_out
);

    localparam int         c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         c_MAG_CLIP = (MAX_BODY > 256) ? 256 : MAX_BODY;
    localparam logic [8:0] c_MAX_MAG  = 9'(c_MAG_CLIP);
    localparam logic [1:0] c_THRESH   = 2'(THRESH);
    localparam logic [1:0] c_IDLE     = 2'b00;
    localparam logic [1:0] c_CNT_MAX  = 2'd3;

    // Per-slot decode (slot index 0 is the oldest instruction, bits [63:48])
    logic [3:0]  w_op   [4];
    logic [7:0]  w_imm  [4];
    logic [15:0] w_pc   [4];
    logic [3:0]  w_cand;

    // Selected candidate
    logic        w_any;
    logic [1:0]  w_sel;
    logic [3:0]  w_keep;
    logic [7:0]  w_sel_imm;
    logic [15:0] w_sel_pc;
    logic [15:0] w_tgt;
    logic [3:0]  w_bus;

    // Confidence table
    logic [DEPTH-1:0] r_vld;
    logic [15:0]      r_tag [DEPTH];
    logic [1:0]       r_cnt [DEPTH];
    logic [c_AW-1:0]  r_alloc;
    logic [DEPTH-1:0] w_hit;
    logic             w_hit_any;
    logic [c_AW-1:0]  w_hit_idx;
    logic [1:0]       w_cur_cnt;
    logic [1:0]       w_new_cnt;
    logic             w_flag;

    // Output registers
    logic [63:0] r_inst;
    logic [63:0] r_pc;
    logic [3:0]  r_vout;
    logic [3:0]  r_bus;
    logic [15:0] r_tgt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [8:0] w_mag;
            assign w_op[gi]  = inst_in[63-16*gi -: 4];
            assign w_imm[gi] = inst_in[63-16*gi-8 -: 8];
            assign w_pc[gi]  = pc_in[63-16*gi -: 16];
            // Magnitude of a negative imm8; only meaningful when bit 7 is set
            assign w_mag      = 9'd256 - {1'b0, w_imm[gi]};
            assign w_cand[gi] = inst_valid_in[3-gi] &&
                                (w_op[gi] == BR_OPCODE) &&
                                w_imm[gi][7] &&
                                (w_mag <= c_MAX_MAG);
        end
    endgenerate

    // Pick the oldest candidate and mask younger (wrong-path) slots
    always_comb begin
        w_any  = |w_cand;
        w_sel  = 2'd0;
        w_keep = 4'b1111;
        for (int i = 3; i >= 0; i--) begin
            if (w_cand[i]) w_sel = 2'(i);
        end
        for (int j = 0; j < 4; j++) begin
            if (w_any && (2'(j) > w_sel)) w_keep[3-j] = 1'b0;
        end
    end

    assign w_sel_imm = w_imm[w_sel];
    assign w_sel_pc  = w_pc[w_sel];
    assign w_tgt     = w_sel_pc + {{8{w_sel_imm[7]}}, w_sel_imm};
    assign w_bus     = 4'b1000 >> w_sel;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign w_hit[gi] = r_vld[gi] && (r_tag[gi] == w_sel_pc);
        end
    endgenerate

    // Tag lookup result and post-update confidence of the selected branch
    always_comb begin
        w_hit_any = |w_hit;
        w_hit_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (w_hit[e]) w_hit_idx = c_AW'(e);
        end
        w_cur_cnt = r_cnt[w_hit_idx];
        if (!w_hit_any)
            w_new_cnt = 2'd1;
        else if (w_cur_cnt == c_CNT_MAX)
            w_new_cnt = c_CNT_MAX;
        else
            w_new_cnt = w_cur_cnt + 2'd1;
        w_flag = w_any && (w_new_cnt >= c_THRESH) && (lbd_state_in == c_IDLE);
    end

    // Confidence table: bump on hit, round-robin allocate on miss
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld   <= '0;
            r_alloc <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_tag[e] <= 16'd0;
                r_cnt[e] <= 2'd0;
            end
        end else if (!mis_pred_in && !stll_ftch_in && w_any) begin
            if (w_hit_any) begin
                r_cnt[w_hit_idx] <= w_new_cnt;
            end else begin
                r_vld[r_alloc] <= 1'b1;
                r_tag[r_alloc] <= w_sel_pc;
                r_cnt[r_alloc] <= 2'd1;
                r_alloc        <= (r_alloc == c_AW'(DEPTH - 1)) ? '0 : r_alloc + 1'b1;
            end
        end
    end

    // Output stage: flush clears qualifiers, stall holds everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inst <= 64'd0;
            r_pc   <= 64'd0;
            r_vout <= 4'd0;
            r_bus  <= 4'd0;
            r_tgt  <= 16'd0;
        end else if (mis_pred_in) begin
            r_inst <= inst_in;
            r_pc   <= pc_in;
            r_vout <= 4'd0;
            r_bus  <= 4'd0;
            r_tgt  <= 16'd0;
        end else if (!stll_ftch_in) begin
            r_inst <= inst_in;
            r_pc   <= pc_in;
            r_vout <= inst_valid_in & w_keep;
            r_bus  <= w_flag ? w_bus : 4'd0;
            r_tgt  <= w_flag ? w_tgt : 16'd0;
        end
    end

    assign inst_out       = r_inst;
    assign pc_out         = r_pc;
    assign inst_valid_out = r_vout;
    assign bck_lp_bus_out = r_bus;
    assign tgt_addr_out   = r_tgt;

endmodule
`default_nettype wire

// File: tb/tb_bck_lp_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_bck_lp_det
// Description : Self-checking bench for bck_lp_det. Stimulus pushes the
//               hand-computed expected output into a queue; a monitor pops
//               and compares one entry after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bck_lp_det;

    typedef struct packed {
        logic [63:0] inst;
        logic [63:0] pc;
        logic [3:0]  vld;
        logic [3:0]  bus;
        logic [15:0] tgt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [63:0] inst_in;
    logic [63:0] pc_in;
    logic [3:0]  inst_valid_in;
    logic        stll_ftch_in;
    logic        mis_pred_in;
    logic [1:0]  lbd_state_in;
    logic [63:0] inst_out;
    logic [63:0] pc_out;
    logic [3:0]  inst_valid_out;
    logic [3:0]  bck_lp_bus_out;
    logic [15:0] tgt_addr_out;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    bck_lp_det dut (
        .clk            (clk),
        .rst            (rst),
        .inst_in        (inst_in),
        .pc_in          (pc_in),
        .inst_valid_in  (inst_valid_in),
        .stll_ftch_in   (stll_ftch_in),
        .mis_pred_in    (mis_pred_in),
        .lbd_state_in   (lbd_state_in),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .inst_valid_out (inst_valid_out),
        .bck_lp_bus_out (bck_lp_bus_out),
        .tgt_addr_out   (tgt_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
        end
    endtask

    // Reset cycle with garbage inputs; stall and flush optionally asserted
    task automatic rst_cycle(input logic st, input logic fl);
        exp_t e;
        @(negedge clk);
        rst           = 1'b0;
        inst_in       = 64'hC0FC_C0FC_C0FC_C0FC;
        pc_in         = 64'hDEAD_BEEF_1234_5678;
        inst_valid_in = 4'hF;
        stll_ftch_in  = st;
        mis_pred_in   = fl;
        lbd_state_in  = 2'b00;
        e = '0;
        q.push_back(e);
        last = e;
        @(posedge clk);
    endtask

    // One functional cycle; ev/eb/et are the hand-computed valid/bus/target
    task automatic step(input logic [63:0] bi, input logic [63:0] bp, input logic [3:0] vin,
                        input logic st, input logic fl, input logic [1:0] lbd,
                        input logic [3:0] ev, input logic [3:0] eb, input logic [15:0] et);
        exp_t e;
        @(negedge clk);
        rst           = 1'b1;
        inst_in       = bi;
        pc_in         = bp;
        inst_valid_in = vin;
        stll_ftch_in  = st;
        mis_pred_in   = fl;
        lbd_state_in  = lbd;
        if (st && !fl) begin
            e = last;
        end else begin
            e.inst = bi;
            e.pc   = bp;
            e.vld  = ev;
            e.bus  = eb;
            e.tgt  = et;
        end
        q.push_back(e);
        last = e;
        @(posedge clk);
    endtask

    // Monitor: one expected entry per clock edge, compared after the edge
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("inst_out",       inst_out,       e.inst);
                chk("pc_out",         pc_out,         e.pc);
                chk("inst_valid_out", {60'd0, inst_valid_out}, {60'd0, e.vld});
                chk("bck_lp_bus_out", {60'd0, bck_lp_bus_out}, {60'd0, e.bus});
                chk("tgt_addr_out",   {48'd0, tgt_addr_out},   {48'd0, e.tgt});
            end
        end
    end

    localparam logic [63:0] c_CONF_I = {16'h1234, 16'hC0FC, 16'h1234, 16'h1234};
    localparam logic [63:0] c_CONF_P = {16'h000E, 16'h0010, 16'h0012, 16'h0014};
    localparam logic [63:0] c_PRI_I  = {16'hC0F0, 16'h1234, 16'hC0FC, 16'h1234};
    localparam logic [63:0] c_PRI_P  = {16'h0200, 16'h0202, 16'h0300, 16'h0206};
    localparam logic [63:0] c_FLT_I  = {16'hC080, 16'hC004, 16'h1234, 16'h1234};
    localparam logic [63:0] c_FLT_P  = {16'h0400, 16'h0402, 16'h0404, 16'h0406};
    localparam logic [63:0] c_BND_I  = {16'hC0C0, 16'h1234, 16'h1234, 16'h1234};
    localparam logic [63:0] c_BND_P  = {16'h0500, 16'h0502, 16'h0504, 16'h0506};
    localparam logic [63:0] c_S3_I   = {16'h1111, 16'h1111, 16'h1111, 16'hC0FE};

    initial begin
        rst = 1'b0; inst_in = '0; pc_in = '0; inst_valid_in = '0;
        stll_ftch_in = 1'b0; mis_pred_in = 1'b0; lbd_state_in = 2'b00;
        last = '0;

        // Reset overrides stall and flush
        rst_cycle(1'b1, 1'b1);
        rst_cycle(1'b0, 1'b0);
        step({16'h1111, 16'h2222, 16'h3333, 16'h4444}, {16'h0100, 16'h0102, 16'h0104, 16'h0106},
             4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);

        // Confidence build-up: slot1 branch at 0x0010, target 0x000C
        step(c_CONF_I, c_CONF_P, 4'hF, 0, 0, 2'b00, 4'hC, 4'h0, 16'h0000);
        step(c_CONF_I, c_CONF_P, 4'hF, 0, 0, 2'b00, 4'hC, 4'h4, 16'h000C);

        // Priority: slot0 wins over slot2
        step(c_PRI_I, c_PRI_P, 4'hF, 0, 0, 2'b00, 4'h8, 4'h0, 16'h0000);
        step(c_PRI_I, c_PRI_P, 4'hF, 0, 0, 2'b00, 4'h8, 4'h8, 16'h01F0);
        // Slot2 branch alone was never counted: first sighting, no flag
        step({16'h1234, 16'h1234, 16'hC0FC, 16'h1234}, c_PRI_P, 4'hF, 0, 0, 2'b00,
             4'hE, 4'h0, 16'h0000);

        // Filters: too-far backward, forward, invalid slot
        step(c_FLT_I, c_FLT_P, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_CONF_I, c_CONF_P, 4'b1011, 0, 0, 2'b00, 4'hB, 4'h0, 16'h0000);
        step(c_FLT_I, c_FLT_P, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        // Boundary |imm8| == MAX_BODY is accepted
        step(c_BND_I, c_BND_P, 4'hF, 0, 0, 2'b00, 4'h8, 4'h0, 16'h0000);
        // 0x0010 survived the filtered bundles (table now full, alloc wrapped)
        step(c_CONF_I, c_CONF_P, 4'hF, 0, 0, 2'b00, 4'hC, 4'h4, 16'h000C);
        step(c_BND_I, c_BND_P, 4'hF, 0, 0, 2'b00, 4'h8, 4'h8, 16'h04C0);

        // Replacement: five new PCs in slot3, fifth evicts the first
        step(c_S3_I, 64'h1000, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1100, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1200, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1300, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1400, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1000, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1000, 4'hF, 0, 0, 2'b00, 4'hF, 4'h1, 16'h0FFE);
        step(c_S3_I, 64'h1400, 4'hF, 0, 0, 2'b00, 4'hF, 4'h1, 16'h13FE);

        // Stall 3 cycles with a new PC: outputs frozen, table untouched
        step(c_S3_I, 64'h1600, 4'hF, 1, 0, 2'b00, 4'h0, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1600, 4'hF, 1, 0, 2'b00, 4'h0, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1600, 4'hF, 1, 0, 2'b00, 4'h0, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1600, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);

        // Flush with stall: data captured, qualifiers cleared, no table write
        step(c_S3_I, 64'h1700, 4'hF, 1, 1, 2'b00, 4'h0, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1700, 4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0000);

        // LAT busy: flag masked but table still trains
        step(c_S3_I, 64'h1800, 4'hF, 0, 0, 2'b01, 4'hF, 4'h0, 16'h0000);
        step(c_S3_I, 64'h1800, 4'hF, 0, 0, 2'b00, 4'hF, 4'h1, 16'h17FE);
        step(c_S3_I, 64'h1000, 4'hF, 0, 0, 2'b01, 4'hF, 4'h0, 16'h0000);

        // Target wraps below zero
        step({16'hC0FC, 16'h1234, 16'h1234, 16'h1234}, {16'h0002, 16'h0004, 16'h0006, 16'h0008},
             4'hF, 0, 0, 2'b00, 4'h8, 4'h0, 16'h0000);
        step({16'hC0FC, 16'h1234, 16'h1234, 16'h1234}, {16'h0002, 16'h0004, 16'h0006, 16'h0008},
             4'hF, 0, 0, 2'b00, 4'h8, 4'h8, 16'hFFFE);

        @(negedge clk);
        stll_ftch_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
